// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit control blocks.
package uart_pkg;

  localparam logic [1:0] RXC_IDLE = 2'd0;
  localparam logic [1:0] RXC_PEND = 2'd1;
  localparam logic [1:0] RXC_PUSH = 2'd2;

  localparam int ST_FULL = 0;
  localparam int ST_PERR = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_TOUT = 3;

  localparam int ENTRY_W = 9;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and host-side signal bundle of uart_rx_ctrl.
interface uart_rx_ctrl_if #(
  parameter int CW = 4
);
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic          rx_err_i;
  logic          rx_busy_i;
  logic [8:0]    data_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;
  logic [3:0]    status_o;
  logic          clr_i;
  logic          irq_o;

  modport slave (
    input  rx_data_i, rx_valid_i, rx_err_i, rx_busy_i, ready_i, clr_i,
    output rx_ready_o, data_o, valid_o, count_o, status_o, irq_o
  );

  modport master (
    output rx_data_i, rx_valid_i, rx_err_i, rx_busy_i, ready_i, clr_i,
    input  rx_ready_o, data_o, valid_o, count_o, status_o, irq_o
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO with wrap-bit pointers.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;

  // A pop in the same cycle frees the slot the write lands in.
  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_comb begin
    wptr_d = wptr_q + CW'(wr_en);
    rptr_d = rptr_q + CW'(rd_en);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Stages received bytes until frame end, tags them with parity status and
// queues them for the host; keeps sticky status, idle timeout and interrupt.
//
//   state | meaning
//   IDLE  | ready for a byte from the receiver
//   PEND  | byte staged, collecting parity error until the frame ends
//   PUSH  | write staged byte into the FIFO (or drop it when full)
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          THRESH      = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd3520
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  uart_rx_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [7:0]         stage_q, stage_d;
  logic               stage_err_q, stage_err_d;
  logic               perr_q, perr_d;
  logic               ovf_q, ovf_d;
  logic               tout_q, tout_d;
  logic               irq_q, irq_d;
  logic [15:0]        tcnt_q, tcnt_d;
  logic [3:0]         status_q, status_d;

  logic               in_idle, in_push;
  logic               pop, accept, drop, idle_ok, tout_set;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count, count_nxt;
  logic [ENTRY_W-1:0] fifo_rdata;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= RXC_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RXC_IDLE: if (bus.rx_valid_i) state_d = RXC_PEND;
      RXC_PEND: if (!bus.rx_busy_i) state_d = RXC_PUSH;
      RXC_PUSH: state_d = RXC_IDLE;
      default:  state_d = RXC_IDLE;
    endcase
  end

  always_comb begin
    in_idle = (state_q == RXC_IDLE);
    in_push = (state_q == RXC_PUSH);
  end

  // Held low while reset is asserted even though the FSM already sits in IDLE.
  assign bus.rx_ready_o = in_idle & rstn_i;

  assign pop    = ~fifo_empty & bus.ready_i;
  assign accept = in_push & (~fifo_full | pop);
  assign drop   = in_push & fifo_full & ~pop;

  always_comb begin
    stage_d     = stage_q;
    stage_err_d = stage_err_q;
    if (in_idle && bus.rx_valid_i) begin
      stage_d     = bus.rx_data_i;
      stage_err_d = 1'b0;
    end else if (state_q == RXC_PEND && bus.rx_err_i) begin
      stage_err_d = 1'b1;
    end
  end

  // Idle-line timer; holds at terminal count once the flag is up.
  always_comb begin
    idle_ok  = ~fifo_empty & ~bus.rx_busy_i & ~pop & ~accept;
    tout_set = 1'b0;
    tcnt_d   = tcnt_q;
    if (!idle_ok) begin
      tcnt_d = '0;
    end else if (!tout_q) begin
      if (tcnt_q == TIMEOUT_CYC - 16'd1) tout_set = 1'b1;
      else                               tcnt_d   = tcnt_q + 16'd1;
    end
  end

  always_comb begin
    perr_d    = (in_push & stage_err_q) | (perr_q & ~bus.clr_i);
    ovf_d     = drop | (ovf_q & ~bus.clr_i);
    tout_d    = tout_set | (tout_q & ~(pop | bus.clr_i));
    count_nxt = fifo_count + CW'(accept) - CW'(pop);
    status_d           = '0;
    status_d[ST_FULL]  = (count_nxt == CW'(DEPTH));
    status_d[ST_PERR]  = perr_d;
    status_d[ST_OVF]   = ovf_d;
    status_d[ST_TOUT]  = tout_d;
    irq_d = (fifo_count >= CW'(THRESH)) | tout_q | perr_q | ovf_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stage_q     <= '0;
      stage_err_q <= 1'b0;
      perr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tout_q      <= 1'b0;
      tcnt_q      <= '0;
      status_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      stage_err_q <= stage_err_d;
      perr_q      <= perr_d;
      ovf_q       <= ovf_d;
      tout_q      <= tout_d;
      tcnt_q      <= tcnt_d;
      status_q    <= status_d;
      irq_q       <= irq_d;
    end
  end

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (in_push),
    .pop_i   (pop),
    .wdata_i ({stage_err_q, stage_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.data_o   = fifo_rdata;
  assign bus.valid_o  = ~fifo_empty;
  assign bus.count_o  = fifo_count;
  assign bus.status_o = status_q;
  assign bus.irq_o    = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized and directed bench for uart_rx_ctrl against a queue-based model.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int          DEPTH  = 8;
  localparam int          THRESH = 4;
  localparam logic [15:0] TOUT   = 16'd50;
  localparam int          CW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.CW(CW)) bus ();

  uart_rx_ctrl #(
    .DEPTH       (DEPTH),
    .THRESH      (THRESH),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // model: queue of host-visible entries plus the byte still held for its frame
  logic [8:0] m_q[$];
  bit         m_staged, m_done, m_err;
  logic [7:0] m_byte;
  bit         m_perr, m_ovf, m_tout, m_irq;
  int         m_run;

  bit rand_mode = 0;
  int pop_pct = 0;
  int clr_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_staged = 0; m_done = 0; m_err = 0; m_byte = 8'h00;
    m_perr = 0; m_ovf = 0; m_tout = 0; m_irq = 0; m_run = 0;
  endtask

  task automatic compare();
    chk("rx_ready", 32'(bus.rx_ready_o), 32'(rstn && !m_staged));
    chk("valid",    32'(bus.valid_o),    32'(m_q.size() > 0));
    chk("count",    32'(bus.count_o),    32'(m_q.size()));
    if (m_q.size() > 0) chk("data", 32'(bus.data_o), 32'(m_q[0]));
    chk("status",   32'(bus.status_o),   32'({m_tout, m_ovf, m_perr, (m_q.size() == DEPTH)}));
    chk("irq",      32'(bus.irq_o),      32'(m_irq));
  endtask

  // advance model by one clock edge using the inputs that edge will sample
  task automatic model_step();
    int n;
    bit pop, acc, drop, idle, tset, commit;
    if (!rstn) begin
      model_reset();
      return;
    end
    n      = m_q.size();
    commit = m_staged && m_done;
    pop    = (n > 0) && bus.ready_i;
    acc    = commit && (n < DEPTH || pop);
    drop   = commit && !acc;
    m_irq  = (n >= THRESH) || m_tout || m_perr || m_ovf;
    idle   = (n > 0) && !bus.rx_busy_i && !pop && !acc;
    if (!idle) m_run = 0;
    else if (!m_tout) m_run++;
    tset   = idle && !m_tout && (m_run >= int'(TOUT));
    m_tout = tset || (m_tout && !(pop || bus.clr_i));
    m_perr = (commit && m_err) || (m_perr && !bus.clr_i);
    m_ovf  = drop || (m_ovf && !bus.clr_i);
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back({m_err, m_byte});
    if (commit) begin
      m_staged = 0;
      m_done   = 0;
    end else if (m_staged) begin
      if (bus.rx_err_i) m_err = 1;
      if (!bus.rx_busy_i) m_done = 1;
    end else if (bus.rx_valid_i) begin
      m_staged = 1;
      m_byte   = bus.rx_data_i;
      m_err    = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      bus.ready_i = (int'($urandom_range(0, 99)) < pop_pct);
      bus.clr_i   = (int'($urandom_range(0, 99)) < clr_pct);
    end
  endtask

  task automatic wait_accept();
    int guard = 0;
    bit r;
    do begin
      r = bus.rx_ready_o;
      tick();
      guard++;
    end while (!r && guard < 20);
    chk("accepted", 32'(r), 32'd1);
    bus.rx_valid_i = 1'b0;
  endtask

  // err_pos == len puts the error pulse on the cycle the frame ends
  task automatic send_frame(input logic [7:0] d, input int len, input int err_pos, input bit pop_in_push);
    bus.rx_data_i  = d;
    bus.rx_valid_i = 1'b1;
    bus.rx_busy_i  = 1'b1;
    wait_accept();
    for (int i = 0; i < len; i++) begin
      bus.rx_err_i = (i == err_pos);
      tick();
    end
    bus.rx_busy_i = 1'b0;
    bus.rx_err_i  = (err_pos == len);
    tick();
    bus.rx_err_i = 1'b0;
    if (pop_in_push) bus.ready_i = 1'b1;
    tick();
    if (pop_in_push) bus.ready_i = 1'b0;
  endtask

  task automatic pop_one();
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
  endtask

  task automatic measure_tout(input string name);
    int n = 0;
    while (!bus.status_o[ST_TOUT] && n < int'(TOUT) + 10) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(TOUT));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"},  32'(bus.rx_ready_o), 32'd0);
    chk({tag, "_valid"},  32'(bus.valid_o),    32'd0);
    chk({tag, "_count"},  32'(bus.count_o),    32'd0);
    chk({tag, "_irq"},    32'(bus.irq_o),      32'd0);
    chk({tag, "_data"},   32'(bus.data_o),     32'd0);
    chk({tag, "_status"}, 32'(bus.status_o),   32'd0);
  endtask

  initial begin
    bus.rx_data_i = 8'h00; bus.rx_valid_i = 1'b0; bus.rx_err_i = 1'b0;
    bus.rx_busy_i = 1'b0;  bus.ready_i = 1'b0;    bus.clr_i = 1'b0;
    model_reset();
    #2;
    check_reset_values("reset");
    tick(); tick();
    rstn = 1'b1;
    tick();

    // single clean byte
    send_frame(8'hA5, 4, -1, 0);
    chk("t1_valid", 32'(bus.valid_o), 32'd1);
    chk("t1_data",  32'(bus.data_o),  32'h0A5);
    chk("t1_count", 32'(bus.count_o), 32'd1);
    tick();
    chk("t1_irq",   32'(bus.irq_o),   32'd0);
    pop_one();

    // parity error tagged onto its byte
    send_frame(8'h3C, 4, 2, 0);
    chk("t2_data", 32'(bus.data_o), 32'h13C);
    chk("t2_perr", 32'(bus.status_o[ST_PERR]), 32'd1);
    tick();
    chk("t2_irq_set", 32'(bus.irq_o), 32'd1);
    clr_pulse();
    chk("t2_perr_clr", 32'(bus.status_o[ST_PERR]), 32'd0);
    tick();
    chk("t2_irq_clr", 32'(bus.irq_o), 32'd0);
    pop_one();

    // threshold and ordering
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 3, -1, 0);
    chk("t3_count", 32'(bus.count_o), 32'd4);
    tick();
    chk("t3_irq", 32'(bus.irq_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", 32'(bus.data_o), 32'(i + 1));
      pop_one();
    end
    chk("t3_empty", 32'(bus.count_o), 32'd0);
    tick();
    chk("t3_irq_low", 32'(bus.irq_o), 32'd0);

    // overflow and push-while-full with a coincident pop
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 2, -1, 0);
    chk("t4_full",  32'(bus.status_o[ST_FULL]), 32'd1);
    chk("t4_count", 32'(bus.count_o), 32'd8);
    send_frame(8'h18, 2, -1, 0);
    chk("t4_ovf",   32'(bus.status_o[ST_OVF]), 32'd1);
    chk("t4_count_hold", 32'(bus.count_o), 32'd8);
    chk("t4_head",  32'(bus.data_o), 32'h010);
    clr_pulse();
    chk("t4_ovf_clr", 32'(bus.status_o[ST_OVF]), 32'd0);
    send_frame(8'h19, 2, -1, 1);
    chk("t4_swap_count", 32'(bus.count_o), 32'd8);
    chk("t4_swap_ovf",   32'(bus.status_o[ST_OVF]), 32'd0);
    chk("t4_swap_head",  32'(bus.data_o), 32'h011);
    bus.ready_i = 1'b1;
    repeat (7) tick();
    chk("t4_tail", 32'(bus.data_o), 32'h019);
    tick();
    bus.ready_i = 1'b0;
    chk("t4_drained", 32'(bus.count_o), 32'd0);

    // idle timeout
    send_frame(8'h5A, 3, -1, 0);
    send_frame(8'h5B, 3, -1, 0);
    measure_tout("t5_cycles_push");
    pop_one();
    chk("t5_pop_clr", 32'(bus.status_o[ST_TOUT]), 32'd0);
    repeat (20) tick();
    chk("t5_no_early", 32'(bus.status_o[ST_TOUT]), 32'd0);
    bus.rx_busy_i = 1'b1;
    repeat (3) tick();
    bus.rx_busy_i = 1'b0;
    measure_tout("t5_cycles_busy");
    tick();
    chk("t5_irq", 32'(bus.irq_o), 32'd1);
    pop_one();
    chk("t5_final_clr", 32'(bus.status_o[ST_TOUT]), 32'd0);

    // asynchronous reset mid-frame
    send_frame(8'h61, 2, -1, 0);
    send_frame(8'h62, 2, 1, 0);
    send_frame(8'h63, 2, -1, 0);
    bus.rx_data_i = 8'h64; bus.rx_valid_i = 1'b1; bus.rx_busy_i = 1'b1;
    wait_accept();
    tick();
    chk("t6_irq_before", 32'(bus.irq_o), 32'd1);
    rstn = 1'b0;
    #1;
    model_reset();
    check_reset_values("t6");
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    bus.rx_busy_i = 1'b0;
    tick();
    send_frame(8'h65, 3, -1, 0);
    chk("t6_head",  32'(bus.data_o),  32'h065);
    chk("t6_count", 32'(bus.count_o), 32'd1);
    pop_one();

    // randomized traffic
    rand_mode = 1;
    clr_pct = 2;
    for (int f = 0; f < 80; f++) begin
      int len, ep;
      pop_pct = (f < 40) ? 15 : 60;
      len = int'($urandom_range(1, 6));
      ep  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      send_frame(8'($urandom), len, ep, 0);
      if ($urandom_range(0, 9) == 0) repeat (int'(TOUT) + 5) tick();
      else repeat (int'($urandom_range(0, 4))) tick();
    end
    rand_mode = 0;
    bus.ready_i = 1'b0;
    bus.clr_i = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
